// File: rtl/comparator_sweep_pkg.sv
// Shared definitions for the comparator sweep controller.
//
// Contents:
//   state_e      - controller FSM states (IDLE, SETTLE, CHECK, DWELL)
//   GLYPH_*      - active-low seven-segment patterns {dp,g,f,e,d,c,b,a}
//                  for the result letters G / L / E / F and a blank digit.
package comparator_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DWELL  = 2'd3
    } state_e;

    localparam logic [7:0] GLYPH_G     = 8'hC2;
    localparam logic [7:0] GLYPH_L     = 8'hC7;
    localparam logic [7:0] GLYPH_E     = 8'h86;
    localparam logic [7:0] GLYPH_F     = 8'h8E;
    localparam logic [7:0] GLYPH_BLANK = 8'hFF;

endpackage

// File: rtl/sseg_glyph_enc.sv
// Combinational glyph encoder: maps the comparator result flags to the
// seven-segment letter shown for one vector.
//
// Ports:
//   gt_i, lt_i, eq_i - comparator flags (expected to be one-hot)
//   glyph_o          - active-low segments; 'F' when the flags are not one-hot
module sseg_glyph_enc
    import comparator_sweep_pkg::*;
(
    input  logic       gt_i,
    input  logic       lt_i,
    input  logic       eq_i,
    output logic [7:0] glyph_o
);

    always_comb begin
        glyph_o = GLYPH_F;
        case ({gt_i, lt_i, eq_i})
            3'b100:  glyph_o = GLYPH_G;
            3'b010:  glyph_o = GLYPH_L;
            3'b001:  glyph_o = GLYPH_E;
            default: glyph_o = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/comparator_sweep_ctrl.sv
// Comparator sweep controller: walks all sixteen 2-bit operand pairs through
// an external comparator, shows each result as a letter on one seven-segment
// digit, and either auto-advances (run=1) or advances on step pulses (run=0).
//
// Optional feature: define SWEEP_SELFCHECK_EN to compare the flags against
// a golden a/b comparison during CHECK; mismatches set a sticky err flag and
// bump a saturating 8-bit err_cnt. Without it err/err_cnt are constant 0.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   run, step                - auto-sweep level / single-step pulse
//   a, b                     - operands driven to the comparator (idx[3:2], idx[1:0])
//   a_gt_b, a_lt_b, a_eq_b   - comparator result flags
//   sseg, sseg_en            - active-low segments and digit enable
//   idx                      - current vector index
//   sweep_done               - one-cycle pulse after vector 15 is checked
//   err, err_cnt             - sticky mismatch flag and mismatch count
module comparator_sweep_ctrl
    import comparator_sweep_pkg::*;
#(
    parameter int DWELL_CYCLES  = 12000000,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    output logic [1:0] a,
    output logic [1:0] b,
    input  logic       a_gt_b,
    input  logic       a_lt_b,
    input  logic       a_eq_b,
    output logic [7:0] sseg,
    output logic       sseg_en,
    output logic [3:0] idx,
    output logic       sweep_done,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam int              DW_W        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST  = DW_W'(DWELL_CYCLES - 1);
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [1:0]      a_q, a_d, b_q, b_d;
    logic [3:0]      settle_q, settle_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic [7:0]      sseg_q, sseg_d;
    logic            done_q, done_d;
    logic            run_q;
    logic [7:0]      glyph;
    logic [3:0]      idx_nxt;
    logic            advance;

    sseg_glyph_enc u_glyph (
        .gt_i    (a_gt_b),
        .lt_i    (a_lt_b),
        .eq_i    (a_eq_b),
        .glyph_o (glyph)
    );

    assign idx_nxt = idx_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        settle_d = settle_q;
        dwell_d  = dwell_q;
        sseg_d   = sseg_q;
        done_d   = 1'b0;
        advance  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run || step) begin
                    state_d  = ST_SETTLE;
                    idx_d    = 4'd0;
                    a_d      = 2'd0;
                    b_d      = 2'd0;
                    settle_d = 4'd0;
                end
            end
            ST_SETTLE: begin
                // Steps arriving here are simply dropped, never remembered.
                if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_CHECK;
                    settle_d = 4'd0;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            ST_CHECK: begin
                sseg_d  = glyph;
                done_d  = (idx_q == 4'd15);
                dwell_d = '0;
                state_d = ST_DWELL;
            end
            ST_DWELL: begin
                if (run) begin
                    // A fresh switch into run mode gets a full dwell period;
                    // step is ignored whenever run is high.
                    if (!run_q) begin
                        dwell_d = '0;
                    end else if (dwell_q == DWELL_LAST) begin
                        advance = 1'b1;
                    end else begin
                        dwell_d = dwell_q + DW_W'(1);
                    end
                end else if (step) begin
                    advance = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            idx_d    = idx_nxt;
            a_d      = idx_nxt[3:2];
            b_d      = idx_nxt[1:0];
            settle_d = 4'd0;
            dwell_d  = '0;
            state_d  = ST_SETTLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= 4'd0;
            a_q      <= 2'd0;
            b_q      <= 2'd0;
            settle_q <= 4'd0;
            dwell_q  <= '0;
            sseg_q   <= GLYPH_BLANK;
            done_q   <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            settle_q <= settle_d;
            dwell_q  <= dwell_d;
            sseg_q   <= sseg_d;
            done_q   <= done_d;
            run_q    <= run;
        end
    end

`ifdef SWEEP_SELFCHECK_EN
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       mismatch;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // The golden flags are always one-hot, so non-one-hot inputs count as a mismatch.
    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        mismatch  = ({a_gt_b, a_lt_b, a_eq_b} != {a_q > b_q, a_q < b_q, a_q == b_q});
        if (state_q == ST_CHECK && mismatch) begin
            err_d     = 1'b1;
            err_cnt_d = sat_inc8(err_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;
`else
    assign err     = 1'b0;
    assign err_cnt = 8'd0;
`endif

    assign a          = a_q;
    assign b          = b_q;
    assign idx        = idx_q;
    assign sseg       = sseg_q;
    assign sseg_en    = (state_q != ST_IDLE) ? 1'b0 : 1'b1;
    assign sweep_done = done_q;

endmodule
